irq_controller: RTL and testbench

- Interrupt source for the CPU. It is the responder to the CPU's int[2:0]/intack handshake.
- Synchronises and edge-detects NUM_SRC external request lines, latches them as pending, masks them, and prioritises them.
- Presents one request at a time to the CPU on int_out[2:0].
- When the CPU acknowledges, it supplies the handler address on the CPU data-in bus. It then holds off further requests until software writes EOI.

---
 rtl/irq_controller.sv | 146 ++++++++++++++
 tb/tb_irq_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller: synchronises and edge-detects external request lines,
// latches them as pending, masks and prioritises them, and hands one request
// at a time to the CPU over the int_out/intack handshake. Once the CPU has
// acknowledged a request, no further request is presented until software
// writes EOI.
module irq_controller #(
  parameter int          NUM_SRC  = 4,
  parameter logic [11:0] VEC_BASE = 12'hBBB
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic [2:0]         int_out,
  input  logic               intack,
  output logic [15:0]        vec_out,
  output logic               vec_oe,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [3:0]         cfg_wdata,
  output logic [3:0]         cfg_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    INSERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_EOI     = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  state_t               state, next_state;
  logic [NUM_SRC-1:0]   sync1, sync2, prev;
  logic [NUM_SRC-1:0]   pending, mask;
  logic [NUM_SRC-1:0]   rise, avail, w1c_clr, ack_clr;
  logic [1:0]           id, pick_id, in_service_id;
  logic [15:0]          vec_reg;
  logic [11:0]          vec_lo;
  logic                 live, ack, eoi_wr;

  // Two-flop synchroniser plus a previous-value flop for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise    = sync2 & ~prev;
  assign avail   = pending & mask;
  assign live    = pending[id] & mask[id];
  assign ack     = (state == REQ) && intack;
  assign eoi_wr  = cfg_we && (cfg_addr == ADDR_EOI);
  assign w1c_clr = (cfg_we && (cfg_addr == ADDR_PENDING)) ? cfg_wdata[NUM_SRC-1:0] : '0;
  assign ack_clr = ack ? (NUM_SRC'(1) << id) : '0;
  assign vec_lo  = VEC_BASE + 12'(pick_id);

  // Lowest-index pending and unmasked source wins.
  always_comb begin
    pick_id = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (avail[i]) pick_id = i[1:0];
    end
  end

  // Pending bits: a fresh edge beats any clear landing in the same cycle.
  // NOTE: the reset branch puts every flop in a known state asynchronously,
  // so a reset mid-handshake cannot leave a stale request behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~(w1c_clr | ack_clr)) | rise;
  end

  // Mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                mask <= '0;
    else if (cfg_we && cfg_addr == ADDR_MASK)  mask <= cfg_wdata[NUM_SRC-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Presented id and its vector are frozen on entry to REQ; the id is
  // remembered as in-service when the CPU acknowledges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id            <= 2'd0;
      vec_reg       <= 16'h0000;
      in_service_id <= 2'd0;
    end else begin
      if (state == IDLE && |avail) begin
        id      <= pick_id;
        vec_reg <= {4'h0, vec_lo};
      end
      if (ack) in_service_id <= id;
    end
  end

  // Next-state logic; an acknowledge takes precedence over a withdraw.
  // NOTE: next_state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (|avail) next_state = REQ;
      REQ: begin
        if (intack)     next_state = INSERVICE;
        else if (!live) next_state = IDLE;
      end
      INSERVICE: if (eoi_wr) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // CPU-facing outputs: request only while in REQ, vector bus only during ack.
  always_comb begin
    int_out = (state == REQ) ? {1'b1, id} : 3'b000;
    vec_oe  = ack;
    vec_out = vec_reg;
  end

  // Register read mux, purely combinational from cfg_addr.
  always_comb begin
    cfg_rdata = 4'h0;
    case (cfg_addr)
      ADDR_MASK:    cfg_rdata = 4'(mask);
      ADDR_PENDING: cfg_rdata = 4'(pending);
      ADDR_EOI:     cfg_rdata = {1'b0, state == INSERVICE, in_service_id};
      ADDR_STATUS:  cfg_rdata = {state, 2'b00};
      default:      cfg_rdata = 4'h0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: directed handshake scenarios followed by
// randomized rounds checked against a transaction-level priority model.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  irq_in = 4'h0;
  logic [2:0]  int_out;
  logic        intack = 1'b0;
  logic [15:0] vec_out;
  logic        vec_oe;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [3:0]  cfg_wdata = 4'h0;
  logic [3:0]  cfg_rdata;

  // Second instance with a base address that wraps.
  logic [3:0]  w_irq_in = 4'h0;
  logic [2:0]  w_int_out;
  logic        w_intack = 1'b0;
  logic [15:0] w_vec_out;
  logic        w_vec_oe;
  logic        w_cfg_we = 1'b0;
  logic [1:0]  w_cfg_addr = 2'd0;
  logic [3:0]  w_cfg_wdata = 4'h0;
  logic [3:0]  w_cfg_rdata;

  int vectors = 0;
  int miscompares = 0;

  irq_controller dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .int_out(int_out),
    .intack(intack), .vec_out(vec_out), .vec_oe(vec_oe),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata)
  );

  irq_controller #(.NUM_SRC(4), .VEC_BASE(12'hFFE)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .irq_in(w_irq_in), .int_out(w_int_out),
    .intack(w_intack), .vec_out(w_vec_out), .vec_oe(w_vec_oe),
    .cfg_we(w_cfg_we), .cfg_addr(w_cfg_addr), .cfg_wdata(w_cfg_wdata),
    .cfg_rdata(w_cfg_rdata)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [3:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [3:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  // Bounded wait for a presented request; an expired bound fails the check.
  task automatic wait_req(input string tag);
    int n = 0;
    while (!int_out[2] && n < 20) begin
      tick();
      n++;
    end
    check(tag, 16'(int_out[2]), 16'h1);
  endtask

  // One-cycle acknowledge; vector bus checked inside the ack cycle.
  task automatic do_ack(input string tag, input logic [15:0] exp_vec);
    intack = 1'b1;
    #1;
    check({tag, "_vec_oe"}, 16'(vec_oe), 16'h1);
    check({tag, "_vec"}, vec_out, exp_vec);
    tick();
    intack = 1'b0;
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  logic [3:0] rd;
  logic [3:0] model_pend, model_mask, edges;
  int         exp_id;
  bit         extra_req;

  initial begin
    // ---- reset state ----
    #3;
    check("rst_int_out", 16'(int_out), 16'h0);
    check("rst_vec_oe", 16'(vec_oe), 16'h0);
    check("rst_vec_out", vec_out, 16'h0000);
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), rd);
      check("rst_rdata", 16'(rd), 16'h0);
    end
    #12 rst_n = 1'b1;
    tick();

    // ---- single source, exact 4-clk latency ----
    cfg_write(2'd0, 4'b0101);
    irq_in = 4'b0100;
    tick();
    irq_in = 4'h0;
    tick();
    tick();
    check("lat_pre_req", 16'(int_out), 16'h0);
    tick();
    check("lat_req", 16'(int_out), 16'b110);
    do_ack("src2", 16'h0BBD);
    cfg_read(2'd1, rd);
    check("src2_pending", 16'(rd), 16'h0);
    cfg_read(2'd3, rd);
    check("src2_status", 16'(rd), 16'b1000);
    cfg_read(2'd2, rd);
    check("src2_eoi_rd", 16'(rd), 16'b0110);
    check("src2_int_off", 16'(int_out), 16'h0);
    cfg_write(2'd2, 4'h0);
    cfg_read(2'd3, rd);
    check("src2_idle", 16'(rd), 16'h0);

    // ---- two sources together, priority and post-EOI timing ----
    cfg_write(2'd0, 4'hF);
    irq_in = 4'b1010;
    tick();
    irq_in = 4'h0;
    wait_req("pri_req");
    check("pri_id1", 16'(int_out), 16'b101);
    do_ack("pri1", 16'h0BBC);
    cfg_write(2'd2, 4'h0);
    tick();
    check("pri_id3_next", 16'(int_out), 16'b111);
    do_ack("pri3", 16'h0BBE);
    cfg_write(2'd2, 4'h0);

    // ---- masked source, then unmask and withdraw ----
    cfg_write(2'd0, 4'h0);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'h0;
    repeat (5) tick();
    check("masked_no_req", 16'(int_out), 16'h0);
    cfg_read(2'd1, rd);
    check("masked_pending", 16'(rd), 16'b0001);
    cfg_write(2'd0, 4'b0001);
    tick();
    check("unmask_req", 16'(int_out), 16'b100);
    cfg_write(2'd0, 4'b0000);
    tick();
    check("withdraw_int", 16'(int_out), 16'h0);
    cfg_read(2'd3, rd);
    check("withdraw_state", 16'(rd), 16'h0);
    cfg_read(2'd1, rd);
    check("withdraw_pending", 16'(rd), 16'b0001);
    cfg_write(2'd1, 4'b0001);
    cfg_read(2'd1, rd);
    check("w1c_clear", 16'(rd), 16'h0);

    // ---- edge set vs W1C in the same cycle, then a held-high line ----
    irq_in = 4'b0100;
    tick();
    tick();
    cfg_write(2'd1, 4'b0100);
    cfg_read(2'd1, rd);
    check("set_beats_clr", 16'(rd), 16'b0100);
    cfg_write(2'd0, 4'b0100);
    wait_req("held_req");
    check("held_id", 16'(int_out), 16'b110);
    do_ack("held", 16'h0BBD);
    cfg_write(2'd2, 4'h0);
    extra_req = 1'b0;
    repeat (50) begin
      tick();
      if (int_out[2]) extra_req = 1'b1;
    end
    check("held_once", 16'(extra_req), 16'h0);
    cfg_read(2'd1, rd);
    check("held_pending", 16'(rd), 16'h0);
    irq_in = 4'h0;

    // ---- wrapping vector base and intack outside REQ ----
    w_cfg_addr = 2'd3;
    w_intack = 1'b1;
    #1;
    check("idle_ack_oe", 16'(w_vec_oe), 16'h0);
    tick();
    w_intack = 1'b0;
    #1;
    check("idle_ack_state", 16'(w_cfg_rdata), 16'h0);
    check("idle_ack_int", 16'(w_int_out), 16'h0);
    w_cfg_we = 1'b1; w_cfg_addr = 2'd0; w_cfg_wdata = 4'b1000;
    tick();
    w_cfg_we = 1'b0;
    w_irq_in = 4'b1000;
    tick();
    w_irq_in = 4'h0;
    begin
      int n = 0;
      while (!w_int_out[2] && n < 20) begin
        tick();
        n++;
      end
    end
    check("wrap_req", 16'(w_int_out), 16'b111);
    w_intack = 1'b1;
    #1;
    check("wrap_vec", w_vec_out, 16'h0001);
    check("wrap_vec_oe", 16'(w_vec_oe), 16'h1);
    tick();
    w_intack = 1'b0;
    w_cfg_addr = 2'd3;
    #1;
    check("wrap_status", 16'(w_cfg_rdata), 16'b1000);

    // ---- asynchronous reset in REQ ----
    cfg_write(2'd0, 4'b0001);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'h0;
    wait_req("rst_req");
    intack = 1'b1;
    #1;
    check("rst_pre_oe", 16'(vec_oe), 16'h1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_int_out", 16'(int_out), 16'h0);
    check("arst_vec_oe", 16'(vec_oe), 16'h0);
    check("arst_vec_out", vec_out, 16'h0000);
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), rd);
      check("arst_rdata", 16'(rd), 16'h0);
    end
    intack = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    cfg_write(2'd0, 4'hF);
    repeat (8) tick();
    check("post_rst_no_req", 16'(int_out), 16'h0);
    cfg_read(2'd1, rd);
    check("post_rst_pending", 16'(rd), 16'h0);

    // ---- randomized rounds against the priority model ----
    model_pend = 4'h0;
    for (int t = 0; t < 20; t++) begin
      model_mask = 4'($urandom_range(0, 15));
      edges      = 4'($urandom_range(0, 15));
      cfg_write(2'd0, model_mask);
      irq_in = edges;
      tick();
      irq_in = 4'h0;
      model_pend = model_pend | edges;
      repeat (5) tick();
      cfg_read(2'd1, rd);
      check("rnd_pending", 16'(rd), 16'(model_pend));
      while ((model_pend & model_mask) != 4'h0) begin
        exp_id = lowest(model_pend & model_mask);
        wait_req("rnd_req");
        check("rnd_id", 16'(int_out), 16'({1'b1, 2'(exp_id)}));
        do_ack("rnd", 16'(12'hBBB + 12'(exp_id)));
        model_pend[exp_id] = 1'b0;
        cfg_write(2'd2, 4'h0);
      end
      repeat (3) tick();
      check("rnd_quiet", 16'(int_out), 16'h0);
      cfg_read(2'd1, rd);
      check("rnd_left", 16'(rd), 16'(model_pend));
      cfg_write(2'd1, 4'hF);
      model_pend = 4'h0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
